// File: rtl/axi4_lite_intf_if.sv
// AXI4-Lite bus bundle shared by the XTS-AES control front end and its master.
// The master modport drives requests and the slave modport drives responses.
interface axi4_lite_intf_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                    awvalid;
    logic                    awready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;
    logic                    arvalid;
    logic                    arready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    rvalid;
    logic                    rready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi4_lite_intf.sv
// AXI4-Lite slave front end: keeps a byte image of master writes, a one-cycle
// "just written" image, and returns read data from a parent-supplied byte array.
// Optional macro AXI4_LITE_INTF_UNALIGNED_SLVERR_EN: unaligned accesses answer
// SLVERR (writes leave the image untouched, reads return zero data).
module axi4_lite_intf #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                               clk,
    input  logic                               reset,
    axi4_lite_intf_if.slave                    bus,
    output logic [(2**ADDR_WIDTH)-1:0][7:0]    reg_written,
    output logic [(2**ADDR_WIDTH)-1:0][7:0]    reg_written_cleared,
    input  logic [(2**ADDR_WIDTH)-1:0][7:0]    reg_to_read,
    output logic [DATA_WIDTH-1:0]              wdata_saved,
    output logic [ADDR_WIDTH-1:0]              waddr_saved,
    output logic [DATA_WIDTH/8-1:0]            wstrb_saved,
    output logic [ADDR_WIDTH-1:0]              raddr_saved,
    output logic                               wr_tran,
    output logic                               onwrite,
    output logic                               rd_tran
);
    localparam int                    LANES       = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LANE_MASK   = ADDR_WIDTH'(LANES - 1);
    localparam logic [1:0]            RESP_OKAY   = 2'b00;
    localparam logic [1:0]            RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {WR_IDLE, WR_COMMIT, WR_RESP} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_FETCH, RD_RESP} rd_state_t;

    wr_state_t             wr_state, wr_next;
    rd_state_t             rd_state, rd_next;
    logic                  aw_held, w_held;
    logic                  aw_hs, w_hs, b_hs, ar_hs;
    logic [1:0]            bresp_q, rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [ADDR_WIDTH-1:0] wbase, rbase;
    logic                  wr_err, rd_err;

    // Word-aligned base byte of each captured address; lanes add on top.
    assign wbase = waddr_saved & ~LANE_MASK;
    assign rbase = raddr_saved & ~LANE_MASK;

`ifdef AXI4_LITE_INTF_UNALIGNED_SLVERR_EN
    assign wr_err = |(waddr_saved & LANE_MASK);
    assign rd_err = |(raddr_saved & LANE_MASK);
`else
    assign wr_err = 1'b0;
    assign rd_err = 1'b0;
`endif

    assign bus.bresp = bresp_q;
    assign bus.rresp = rresp_q;
    assign bus.rdata = rdata_q;

    // State registers for the independent write and read sequencers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            wr_state <= WR_IDLE;
            rd_state <= RD_IDLE;
        end else begin
            wr_state <= wr_next;
            rd_state <= rd_next;
        end
    end

    // Write sequencer: collect AW and W, commit for one cycle, then hold B.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case leaves a signal unassigned and infers a latch.
        wr_next     = wr_state;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        wr_tran     = 1'b0;
        aw_hs       = 1'b0;
        w_hs        = 1'b0;
        b_hs        = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                bus.awready = !reset && !aw_held;
                bus.wready  = !reset && !w_held;
                aw_hs       = bus.awvalid && bus.awready;
                w_hs        = bus.wvalid && bus.wready;
                if ((aw_held || aw_hs) && (w_held || w_hs))
                    wr_next = WR_COMMIT;
            end
            WR_COMMIT: begin
                wr_tran = !reset;
                wr_next = WR_RESP;
            end
            WR_RESP: begin
                bus.bvalid = !reset;
                b_hs       = bus.bvalid && bus.bready;
                if (b_hs)
                    wr_next = WR_IDLE;
            end
            default: wr_next = WR_IDLE;
        endcase
        onwrite = w_hs;
    end

    // Read sequencer: accept AR, sample the parent array once, hold R.
    always_comb begin
        rd_next     = rd_state;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        rd_tran     = 1'b0;
        ar_hs       = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                bus.arready = !reset;
                ar_hs       = bus.arvalid && bus.arready;
                if (ar_hs)
                    rd_next = RD_FETCH;
            end
            RD_FETCH: begin
                rd_tran = !reset;
                rd_next = RD_RESP;
            end
            RD_RESP: begin
                bus.rvalid = !reset;
                if (bus.rready)
                    rd_next = RD_IDLE;
            end
            default: rd_next = RD_IDLE;
        endcase
    end

    // Write datapath: holding registers, byte image and one-cycle image.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the byte images are cleared on reset because the parent
            // treats an all-zero image as "nothing configured" after an abort.
            reg_written         <= '0;
            reg_written_cleared <= '0;
            aw_held             <= 1'b0;
            w_held              <= 1'b0;
            waddr_saved         <= '0;
            wdata_saved         <= '0;
            wstrb_saved         <= '0;
            bresp_q             <= RESP_OKAY;
        end else begin
            reg_written_cleared <= '0;
            if (aw_hs) begin
                aw_held     <= 1'b1;
                waddr_saved <= bus.awaddr;
            end
            if (w_hs) begin
                w_held      <= 1'b1;
                wdata_saved <= bus.wdata;
                wstrb_saved <= bus.wstrb;
            end
            if (b_hs) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
            if (wr_tran) begin
                bresp_q <= wr_err ? RESP_SLVERR : RESP_OKAY;
                for (int i = 0; i < LANES; i++) begin
                    if (!wr_err && wstrb_saved[i]) begin
                        reg_written[wbase + ADDR_WIDTH'(i)]         <= wdata_saved[8*i +: 8];
                        reg_written_cleared[wbase + ADDR_WIDTH'(i)] <= wdata_saved[8*i +: 8];
                    end
                end
            end
        end
    end

    // Read datapath: capture address, then sample the addressed word once.
    always_ff @(posedge clk) begin
        if (reset) begin
            raddr_saved <= '0;
            rdata_q     <= '0;
            rresp_q     <= RESP_OKAY;
        end else begin
            if (ar_hs)
                raddr_saved <= bus.araddr;
            if (rd_tran) begin
                rresp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
                for (int i = 0; i < LANES; i++)
                    rdata_q[8*i +: 8] <= rd_err ? 8'h00 : reg_to_read[rbase + ADDR_WIDTH'(i)];
            end
        end
    end
endmodule

// File: tb/tb_axi4_lite_intf.sv
// Scoreboard bench for axi4_lite_intf: directed transactions push expected
// write commits and B/R responses; monitors pop and compare as the DUT presents them.
module tb_axi4_lite_intf;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int NB = 2**AW;

    typedef logic [NB-1:0][7:0] img_t;
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [3:0]    strb;
    } wr_exp_t;
    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } rd_exp_t;

    logic          clk;
    logic          reset;
    img_t          reg_written;
    img_t          reg_written_cleared;
    img_t          reg_to_read;
    logic [DW-1:0] wdata_saved;
    logic [AW-1:0] waddr_saved;
    logic [3:0]    wstrb_saved;
    logic [AW-1:0] raddr_saved;
    logic          wr_tran, onwrite, rd_tran;

    axi4_lite_intf_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    axi4_lite_intf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk                 (clk),
        .reset               (reset),
        .bus                 (bus),
        .reg_written         (reg_written),
        .reg_written_cleared (reg_written_cleared),
        .reg_to_read         (reg_to_read),
        .wdata_saved         (wdata_saved),
        .waddr_saved         (waddr_saved),
        .wstrb_saved         (wstrb_saved),
        .raddr_saved         (raddr_saved),
        .wr_tran             (wr_tran),
        .onwrite             (onwrite),
        .rd_tran             (rd_tran)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int        n_checks = 0;
    int        n_fail   = 0;
    int        rd_count = 0;
    wr_exp_t   exp_wr[$];
    logic [1:0] exp_b[$];
    rd_exp_t   exp_r[$];
    img_t      model_img;
    img_t      model_clr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int diff_idx(input img_t a, input img_t b);
        for (int i = 0; i < NB; i++)
            if (a[i] !== b[i]) return i;
        return 0;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Write commit monitor: checks saved beat, image update and one-cycle image.
    always begin : wr_mon
        wr_exp_t e;
        int      idx;
        int      base;
        @(negedge clk);
        if (reset) begin
            model_img = '0;
        end else if (wr_tran) begin
            if (exp_wr.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL wr_unexpected: wr_tran with no queued write");
            end else begin
                e = exp_wr.pop_front();
                check("waddr_saved", waddr_saved, e.addr);
                check("wdata_saved", wdata_saved, e.data);
                check("wstrb_saved", wstrb_saved, e.strb);
                model_clr = '0;
                base = int'(e.addr) & ~3;
                for (int i = 0; i < 4; i++) begin
                    if (e.strb[i]) begin
                        model_img[base + i] = e.data[8*i +: 8];
                        model_clr[base + i] = e.data[8*i +: 8];
                    end
                end
                @(negedge clk);
                check("wr_tran_one_cycle", wr_tran, 1'b0);
                idx = diff_idx(reg_written, model_img);
                check($sformatf("reg_written[0x%0h]", idx), reg_written[idx], model_img[idx]);
                idx = diff_idx(reg_written_cleared, model_clr);
                check($sformatf("reg_written_cleared[0x%0h]", idx), reg_written_cleared[idx], model_clr[idx]);
                @(negedge clk);
                check("cleared_after_one_cycle", |reg_written_cleared, 1'b0);
            end
        end
    end

    // B response monitor.
    always begin : b_mon
        @(negedge clk);
        if (!reset && bus.bvalid && bus.bready) begin
            if (exp_b.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL b_unexpected: bvalid with no queued write response");
            end else begin
                check("bresp", bus.bresp, exp_b.pop_front());
            end
        end
    end

    // R response monitor.
    always begin : r_mon
        rd_exp_t r;
        @(negedge clk);
        if (!reset && bus.rvalid && bus.rready) begin
            if (exp_r.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL r_unexpected: rvalid with no queued read response");
            end else begin
                r = exp_r.pop_front();
                check("rdata", bus.rdata, r.data);
                check("rresp", bus.rresp, r.resp);
            end
        end
    end

    // Counts rd_tran pulses seen outside reset.
    always begin : rd_cnt
        @(negedge clk);
        if (!reset && rd_tran) rd_count++;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        reset       = 1'b1;
        reg_to_read = '0;
        bus.awvalid = 1'b0; bus.awaddr = '0;
        bus.wvalid  = 1'b0; bus.wdata  = '0; bus.wstrb = '0;
        bus.bready  = 1'b0;
        bus.arvalid = 1'b0; bus.araddr = '0;
        bus.rready  = 1'b0;

        // Reset state.
        tick(3);
        check("awready_in_reset", bus.awready, 1'b0);
        check("arready_in_reset", bus.arready, 1'b0);
        reset = 1'b0;
        #1;
        check("reg_written_zero", |reg_written, 1'b0);
        check("awready_after_reset", bus.awready, 1'b1);
        check("wready_after_reset", bus.wready, 1'b1);
        check("arready_after_reset", bus.arready, 1'b1);
        check("bvalid_after_reset", bus.bvalid, 1'b0);
        check("rvalid_after_reset", bus.rvalid, 1'b0);

        // AW and W on the same edge.
        bus.bready  = 1'b1;
        bus.awaddr  = 10'h010; bus.awvalid = 1'b1;
        bus.wdata   = 32'hA5A5_0001; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        exp_wr.push_back('{10'h010, 32'hA5A5_0001, 4'hF});
        exp_b.push_back(2'b00);
        #1;
        check("onwrite_same_edge", onwrite, 1'b1);
        tick(1);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        #1;
        check("wr_tran_same_edge", wr_tran, 1'b1);
        tick(1);
        check("bvalid_t1", bus.bvalid, 1'b1);
        check("reg_0x10", reg_written[10'h010], 8'h01);
        check("reg_0x13", reg_written[10'h013], 8'hA5);
        check("clr_0x10", reg_written_cleared[10'h010], 8'h01);
        tick(1);
        check("clr_0x10_gone", reg_written_cleared[10'h010], 8'h00);
        check("bvalid_dropped_t1", bus.bvalid, 1'b0);
        check("awready_back_t1", bus.awready, 1'b1);

        // W first, AW three cycles later, sparse strobe.
        bus.wdata = 32'h1122_3344; bus.wstrb = 4'b0101; bus.wvalid = 1'b1;
        exp_wr.push_back('{10'h004, 32'h1122_3344, 4'b0101});
        exp_b.push_back(2'b00);
        #1;
        check("onwrite_w_first", onwrite, 1'b1);
        tick(1);
        bus.wvalid = 1'b0;
        #1;
        check("wready_held", bus.wready, 1'b0);
        check("awready_open", bus.awready, 1'b1);
        check("onwrite_single", onwrite, 1'b0);
        check("no_wr_tran_w_only_a", wr_tran, 1'b0);
        tick(2);
        check("no_wr_tran_w_only_b", wr_tran, 1'b0);
        bus.awaddr = 10'h004; bus.awvalid = 1'b1;
        #1;
        check("onwrite_on_aw", onwrite, 1'b0);
        tick(1);
        bus.awvalid = 1'b0;
        #1;
        check("wr_tran_after_aw", wr_tran, 1'b1);
        tick(1);
        check("reg_0x04", reg_written[10'h004], 8'h44);
        check("reg_0x05", reg_written[10'h005], 8'h00);
        check("reg_0x06", reg_written[10'h006], 8'h22);
        check("reg_0x07", reg_written[10'h007], 8'h00);
        check("reg_0x10_kept", reg_written[10'h010], 8'h01);
        tick(1);

        // Read with rready held low for four cycles.
        reg_to_read[10'h200] = 8'hDE;
        reg_to_read[10'h201] = 8'hAD;
        reg_to_read[10'h202] = 8'hBE;
        reg_to_read[10'h203] = 8'hEF;
        bus.araddr = 10'h200; bus.arvalid = 1'b1;
        exp_r.push_back('{32'hEFBE_ADDE, 2'b00});
        #1;
        check("arready_idle", bus.arready, 1'b1);
        tick(1);
        bus.arvalid = 1'b0;
        #1;
        check("rd_tran_pulse", rd_tran, 1'b1);
        check("arready_busy", bus.arready, 1'b0);
        check("raddr_saved", raddr_saved, 10'h200);
        tick(1);
        check("rvalid_up", bus.rvalid, 1'b1);
        check("rdata_first", bus.rdata, 32'hEFBE_ADDE);
        check("rd_tran_gone", rd_tran, 1'b0);
        reg_to_read[10'h200] = 8'h00;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            check($sformatf("rvalid_hold%0d", k), bus.rvalid, 1'b1);
            check($sformatf("rdata_hold%0d", k), bus.rdata, 32'hEFBE_ADDE);
        end
        bus.rready = 1'b1;
        tick(1);
        bus.rready = 1'b0;
        #1;
        check("rvalid_dropped", bus.rvalid, 1'b0);
        check("arready_back", bus.arready, 1'b1);
        check("rd_tran_count", rd_count, 1);

        // B back-pressure blocks a second write until bready.
        bus.bready = 1'b0;
        bus.awaddr = 10'h020; bus.awvalid = 1'b1;
        bus.wdata  = 32'hCAFE_F00D; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        exp_wr.push_back('{10'h020, 32'hCAFE_F00D, 4'hF});
        exp_b.push_back(2'b00);
        tick(1);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        tick(1);
        bus.awaddr = 10'h024; bus.awvalid = 1'b1;
        bus.wdata  = 32'h0102_0304; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp_bvalid%0d", k), bus.bvalid, 1'b1);
            check($sformatf("bp_awready%0d", k), bus.awready, 1'b0);
            check($sformatf("bp_wready%0d", k), bus.wready, 1'b0);
            tick(1);
        end
        exp_wr.push_back('{10'h024, 32'h0102_0304, 4'hF});
        exp_b.push_back(2'b00);
        bus.bready = 1'b1;
        tick(1);
        check("awready_after_b", bus.awready, 1'b1);
        check("wready_after_b", bus.wready, 1'b1);
        tick(1);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        #1;
        check("wr_tran_second", wr_tran, 1'b1);
        tick(1);
        check("bvalid_second", bus.bvalid, 1'b1);
        check("reg_0x20", reg_written[10'h020], 8'h0D);
        check("reg_0x24", reg_written[10'h024], 8'h04);
        check("reg_0x27", reg_written[10'h027], 8'h01);
        tick(1);

        // Reset during an outstanding read and write aborts both.
        bus.awaddr = 10'h030; bus.awvalid = 1'b1;
        bus.wdata  = 32'hFFFF_FFFF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        bus.araddr = 10'h204; bus.arvalid = 1'b1;
        bus.rready = 1'b1;
        tick(1);
        reset = 1'b1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        #1;
        check("abort_wr_tran", wr_tran, 1'b0);
        check("abort_rd_tran", rd_tran, 1'b0);
        check("abort_awready", bus.awready, 1'b0);
        check("abort_arready", bus.arready, 1'b0);
        tick(1);
        check("abort_img_zero", |reg_written, 1'b0);
        check("abort_rdata_zero", bus.rdata, 32'h0);
        check("abort_waddr_zero", waddr_saved, 10'h0);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            check($sformatf("abort_bvalid%0d", k), bus.bvalid, 1'b0);
            check($sformatf("abort_rvalid%0d", k), bus.rvalid, 1'b0);
        end
        check("abort_awready_back", bus.awready, 1'b1);
        check("abort_arready_back", bus.arready, 1'b1);
        check("abort_img_still_zero", |reg_written, 1'b0);
        check("abort_clr_zero", |reg_written_cleared, 1'b0);

        // Every queued expectation was consumed.
        check("exp_wr_drained", exp_wr.size(), 0);
        check("exp_b_drained", exp_b.size(), 0);
        check("exp_r_drained", exp_r.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
